// File: rtl/y86_mem_arbiter.sv
// Two-master arbiter and wait-state sequencer for the y86 single-port memory.
// Build option: define ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
`timescale 1ns/1ps
module y86_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_A,
    output logic          mem_RE,
    output logic          mem_WE,
    output logic [DW-1:0] mem_out,
    input  logic [DW-1:0] mem_in,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("y86_mem_arbiter: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic [3:0]    r_cnt;
    logic          r_gnt0;
    logic          r_gnt1;
    logic          w_anyReq;
    logic          w_sel;

    assign w_anyReq = m0_req | m1_req;

`ifdef ARB_FIXED_PRIO_EN
    assign w_sel = ~m0_req;
`else
    logic r_last;

    // The master served last loses the next tie; starts at 1 so m0 wins the first.
    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b1;
        else if (r_state == DONE)
            r_last <= r_owner;
    end

    assign w_sel = (m0_req && m1_req) ? ~r_last : m1_req;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        mem_A     = '0;
        mem_out   = '0;
        mem_RE    = 1'b0;
        mem_WE    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_anyReq)
                    w_next = ACCESS;
            end
            ACCESS: begin
                mem_A   = r_addr;
                mem_out = r_wdata;
                mem_RE  = ~r_we;
                mem_WE  = r_we;
                if (r_cnt == 4'd0)
                    w_next = DONE;
            end
            DONE: begin
                m0_rvalid = ~r_owner;
                m1_rvalid = r_owner;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Transaction latch, wait counter, grant pulse and per-master read data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_cnt    <= 4'd0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_owner <= w_sel;
                        r_we    <= w_sel ? m1_we    : m0_we;
                        r_addr  <= w_sel ? m1_addr  : m0_addr;
                        r_wdata <= w_sel ? m1_wdata : m0_wdata;
                        r_cnt   <= LP_WAIT;
                        r_gnt0  <= ~w_sel;
                        r_gnt1  <= w_sel;
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            if (r_owner)
                                r_rdata1 <= mem_in;
                            else
                                r_rdata0 <= mem_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m0_gnt   = r_gnt0;
    assign m1_gnt   = r_gnt1;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;

endmodule

// File: doc/y86_mem_arbiter.md
# y86_mem_arbiter

Two-master arbiter and sequencer for the single-port memory behind the y86 core's bus. It shares one memory between master 0 (the sequential core's fetch/load/store port) and master 1 (the debug/program loader port). It grants one transaction at a time, drives the memory strobes for a programmable number of wait states, and returns read data or a write acknowledge to the owner. It sits between the core's bus signals and the memory model.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- WAIT_CYCLES, 1, extra memory cycles per access (0..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- m0_req / m1_req  in  1  transaction request, held until gnt
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  one-cycle pulse: request accepted
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse: transaction complete (read data valid, or write done)
- m0_rdata / m1_rdata  out  DW  read data, valid while rvalid
- mem_A  out  AW  memory address
- mem_RE  out  1  memory read strobe
- mem_WE  out  1  memory write strobe
- mem_out  out  DW  memory write data
- mem_in  in  DW  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, DONE. Reset value is IDLE.
- IDLE:
  - If any req is sampled high at the edge, select the owner and latch owner, we, addr, wdata.
  - Load the wait counter with WAIT_CYCLES and go to ACCESS.
- Selection (round-robin):
  - A single requester wins.
  - When both request, the winner is the master not served last.
  - The `last` pointer resets to 1, so m0 wins the first tie.
- ACCESS:
  - mem_A, mem_out, and mem_RE (read) or mem_WE (write) are driven from the latched registers for WAIT_CYCLES+1 cycles.
  - The counter decrements each cycle. At count 0, a read captures mem_in into the rdata register, and the state moves to DONE.
- DONE:
  - Pulse rvalid to the owner for one cycle.
  - Update `last` to the owner and return to IDLE.
- gnt for the owner pulses in the first ACCESS cycle. The master may change its req/addr from the following cycle.
- A req that drops during ACCESS/DONE is ignored; the latched transaction completes.
- Non-owner rvalid/gnt stay 0. rdata of each master holds its last read value; writes do not change it.
- mem_A, mem_out and rdata are 0 when idle after reset. mem_A and mem_out are driven 0 outside ACCESS.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from req to any output.
- Reset values: all gnt, rvalid, mem_RE, mem_WE and busy are 0; all data/address outputs are 0; state is IDLE; last = 1.
- Latency, with req sampled at edge 0:
  - gnt and the first strobe in cycle 1.
  - Strobe cycles 1..1+W, where W = WAIT_CYCLES.
  - rvalid in cycle 2+W.
  - IDLE in cycle 3+W.
  - The next grant is in cycle 4+W at the earliest, so throughput is one transaction per W+3 cycles.
- Simultaneous continuous requests from both masters are granted in strict alternation.
- rst asserted mid-transaction: at that edge, strobes drop, state returns to IDLE, no rvalid is issued, and the pointer is reinitialised.
- The wait counter is 4 bits. WAIT_CYCLES > 15 is illegal and must be rejected at elaboration.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: m0 always wins a tie and the `last` pointer is unused. m1 is served only when m0_req is low in IDLE.
  - Undefined (default): round-robin as above.

## Test plan
- WAIT_CYCLES=1, m0 read of addr 0x10 with mem returning 0xDEADBEEF → m0_gnt in cycle 1, mem_RE high cycles 1–2, m0_rvalid in cycle 3 with m0_rdata=0xDEADBEEF.
- m1 write of 0x12345678 to 0x40 with WAIT_CYCLES=0 → mem_WE high for exactly 1 cycle with mem_A=0x40 and mem_out=0x12345678, then m1_rvalid, and m1_rdata unchanged.
- Both masters request continuously from reset → grants go m0, m1, m0, m1, with each grant W+3 cycles apart.
- rst raised in the second ACCESS cycle of a read → strobes 0 next cycle, no rvalid, busy=0. The next tie grants m0.
- m0_req dropped in the cycle after gnt → the transaction still completes with rvalid.
- Compiled with ARB_FIXED_PRIO_EN and both requesting continuously → only m0 is ever granted. After m0 goes idle, m1 is granted in the next IDLE.
